rv32_multicycle_core: RTL and testbench

- Parametrised multi-cycle RV32I core: datapath and sequencing FSM in one block.
- Executes R, I, load, store, branch, LUI, AUIPC, JAL and JALR instructions.
- Compared with the single-cycle datapath it adds:
  - a handshaked data bus with wait states;
  - byte and halfword loads and stores;
  - a configurable register count (RV32I/RV32E);
  - a programmable reset PC;
  - an illegal-instruction trap.
- Connects to combinational instruction memory and a ready-handshaked data bus, in place of the single-cycle datapath plus control unit.

---
 rtl/rv32_mc_pkg.sv | 65 ++++++
 rtl/rv32_mc_alu.sv | 53 +++++
 rtl/rv32_multicycle_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_rv32_multicycle_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mc_pkg.sv
// ============================================================================
// Module      : rv32_mc_pkg
// Description : Shared opcodes, funct3 codes, ALU ops and FSM states for the
//               multi-cycle RV32I core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_mc_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
    } state_e;

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic alu_op_e alu_op_decode(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_mc_alu.sv
// ============================================================================
// Module      : rv32_mc_alu
// Description : Combinational RV32I ALU plus independent branch comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_mc_alu
    import rv32_mc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    input  logic [31:0] cmp_a,
    input  logic [31:0] cmp_b,
    input  logic [2:0]  br_funct3,
    output logic [31:0] result,
    output logic        br_taken
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (br_funct3)
            F3_BEQ:  br_taken = (cmp_a == cmp_b);
            F3_BNE:  br_taken = (cmp_a != cmp_b);
            F3_BLT:  br_taken = ($signed(cmp_a) < $signed(cmp_b));
            F3_BGE:  br_taken = ($signed(cmp_a) >= $signed(cmp_b));
            F3_BLTU: br_taken = (cmp_a < cmp_b);
            F3_BGEU: br_taken = (cmp_a >= cmp_b);
            default: br_taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rv32_multicycle_core.sv
// ============================================================================
// Module      : rv32_multicycle_core
// Description : Multi-cycle RV32I/RV32E core with handshaked data bus and trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_multicycle_core
    import rv32_mc_pkg::*;
#(
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instrMemAddr,
    input  logic [31:0] instrCode,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWData,
    output logic [3:0]  busBe,
    input  logic [31:0] busRData,
    input  logic        busReady,
    output logic        illegalInstr
);

    localparam int          RIDX_W = $clog2(NUM_REGS);
    localparam logic [5:0]  NREGS6 = 6'(NUM_REGS);

    state_e      state;
    logic [31:0] pc, ir, op_a, op_b, imm, alu_out, mdr;
    logic [31:0] rf [NUM_REGS];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    assign instrMemAddr = pc;

    logic        legal, use_rs1, use_rs2, use_rd, bad_reg;
    logic [31:0] imm_dec, rs1_val, rs2_val;

    always_comb begin
        legal = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0; imm_dec = '0;
        case (opcode)
            OPC_OP: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            OPC_OPIMM: begin
                legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                        (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm_dec = {{20{ir[31]}}, ir[31:20]};
            end
            OPC_LOAD: begin
                legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                        (f3 == F3_LBU) || (f3 == F3_LHU);
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm_dec = {{20{ir[31]}}, ir[31:20]};
            end
            OPC_STORE: begin
                legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OPC_JALR: begin
                legal = (f3 == 3'b000);
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm_dec = {{20{ir[31]}}, ir[31:20]};
            end
            OPC_JAL: begin
                legal = 1'b1; use_rd = 1'b1;
                imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                legal = 1'b1; use_rd = 1'b1;
                imm_dec = {ir[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    // Index check keeps RV32E from touching x16..x31 that do not exist
    assign bad_reg = (use_rs1 && {1'b0, rs1} >= NREGS6) ||
                     (use_rs2 && {1'b0, rs2} >= NREGS6) ||
                     (use_rd  && {1'b0, rd}  >= NREGS6);

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1[RIDX_W-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2[RIDX_W-1:0]];

    logic [31:0] alu_a, alu_b, alu_res, jump_target, store_data, lane, load_val, wb_val;
    alu_op_e     alu_op;
    logic        br_taken, is_jump, misaligned;
    logic [3:0]  be_calc;

    always_comb begin
        alu_a = op_a; alu_b = imm; alu_op = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                alu_b  = op_b;
                alu_op = alu_op_decode(f3, f7[5]);
            end
            OPC_OPIMM:                     alu_op = alu_op_decode(f3, f3 == 3'b101 && f7[5]);
            OPC_LUI:                       alu_a  = '0;
            OPC_AUIPC, OPC_JAL, OPC_BRANCH: alu_a = pc;
            default: ;
        endcase
    end

    rv32_mc_alu u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .op        (alu_op),
        .cmp_a     (op_a),
        .cmp_b     (op_b),
        .br_funct3 (f3),
        .result    (alu_res),
        .br_taken  (br_taken)
    );

    assign is_jump     = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign jump_target = (opcode == OPC_JALR) ? {alu_res[31:1], 1'b0} : alu_res;
    assign misaligned  = (f3[1:0] == 2'b01 && alu_res[0]) ||
                         (f3[1:0] == 2'b10 && alu_res[1:0] != 2'b00);

    always_comb begin
        case (f3[1:0])
            2'b00:   begin be_calc = 4'b0001 << alu_res[1:0]; store_data = {4{op_b[7:0]}};  end
            2'b01:   begin be_calc = 4'b0011 << alu_res[1:0]; store_data = {2{op_b[15:0]}}; end
            default: begin be_calc = 4'b1111;                 store_data = op_b;            end
        endcase
    end

    assign lane = busRData >> {busAddr[1:0], 3'b000};
    always_comb begin
        case (f3)
            F3_LB:   load_val = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   load_val = {{16{lane[15]}}, lane[15:0]};
            F3_LBU:  load_val = {24'b0, lane[7:0]};
            F3_LHU:  load_val = {16'b0, lane[15:0]};
            default: load_val = busRData;
        endcase
    end

    assign wb_val = (opcode == OPC_LOAD) ? mdr : is_jump ? pc + 32'd4 : alu_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc <= RESET_PC;
            ir <= '0; op_a <= '0; op_b <= '0; imm <= '0; alu_out <= '0; mdr <= '0;
            busReq <= 1'b0; busWe <= 1'b0; busAddr <= '0; busWData <= '0; busBe <= '0;
            illegalInstr <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= instrCode;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    op_a <= rs1_val;
                    op_b <= rs2_val;
                    imm  <= imm_dec;
                    if (!legal || bad_reg) begin
                        state <= S_TRAP;
                        illegalInstr <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    alu_out <= is_jump ? jump_target : alu_res;
                    if (opcode == OPC_BRANCH) begin
                        pc    <= br_taken ? alu_res : pc + 32'd4;
                        state <= S_FETCH;
                    end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                        if (misaligned) begin
                            state <= S_TRAP;
                            illegalInstr <= 1'b1;
                        end else begin
                            busReq   <= 1'b1;
                            busWe    <= (opcode == OPC_STORE);
                            busAddr  <= alu_res;
                            busBe    <= be_calc;
                            busWData <= store_data;
                            state    <= S_MEM;
                        end
                    end else if (is_jump && jump_target[1]) begin
                        state <= S_TRAP;
                        illegalInstr <= 1'b1;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (busReady) begin
                        busReq <= 1'b0;
                        busWe  <= 1'b0;
                        if (busWe) begin
                            pc    <= pc + 32'd4;
                            state <= S_FETCH;
                        end else begin
                            mdr   <= load_val;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc    <= is_jump ? alu_out : pc + 32'd4;
                    state <= S_FETCH;
                end
                S_TRAP: ;
                default: begin
                    state <= S_TRAP;
                    illegalInstr <= 1'b1;
                end
            endcase
        end
    end

    // Register file is deliberately left without reset
    always_ff @(posedge clk) begin
        if (state == S_WB && rd != 5'd0)
            rf[rd[RIDX_W-1:0]] <= wb_val;
    end

endmodule

`default_nettype wire

// File: tb/tb_rv32_multicycle_core.sv
// ============================================================================
// Module      : tb_rv32_multicycle_core
// Description : Table-driven program walk plus reset/trap corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main core: RESET_PC 0, RV32I
    logic        rst_m;
    logic [31:0] pc_m, instr_m, addr_m, wdata_m, rdata_m;
    logic        req_m, we_m, ready_m, ill_m;
    logic [3:0]  be_m;
    logic [31:0] imem [0:63];
    assign instr_m = imem[pc_m[7:2]];

    rv32_multicycle_core #(.NUM_REGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(rst_m), .instrMemAddr(pc_m), .instrCode(instr_m),
        .busReq(req_m), .busWe(we_m), .busAddr(addr_m), .busWData(wdata_m),
        .busBe(be_m), .busRData(rdata_m), .busReady(ready_m), .illegalInstr(ill_m)
    );

    // Second core: RESET_PC 0x100, RV32E, always fed ADD x20,x1,x2
    logic        rst_e;
    logic [31:0] pc_e, addr_e, wdata_e;
    logic        req_e, we_e, ill_e;
    logic [3:0]  be_e;
    logic [31:0] instr_e = 32'h00208A33;
    logic [31:0] rdata_e = 32'h0;
    logic        ready_e = 1'b0;

    rv32_multicycle_core #(.NUM_REGS(16), .RESET_PC(32'h100)) dut_e (
        .clk(clk), .reset(rst_e), .instrMemAddr(pc_e), .instrCode(instr_e),
        .busReq(req_e), .busWe(we_e), .busAddr(addr_e), .busWData(wdata_e),
        .busBe(be_e), .busRData(rdata_e), .busReady(ready_e), .illegalInstr(ill_e)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          rd;
        logic [31:0] val;
        logic [31:0] next_pc;
        int          cycles;
        int          mem;      // 0 none, 1 load, 2 store
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr, input int rd,
                                input logic [31:0] val, input logic [31:0] npc, input int cyc,
                                input int mem, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int wt);
        vec_t v;
        v.pc = pc; v.instr = instr; v.rd = rd; v.val = val; v.next_pc = npc; v.cycles = cyc;
        v.mem = mem; v.addr = addr; v.be = be; v.wdata = wdata; v.rdata = rdata; v.wait_n = wt;
        return v;
    endfunction

    vec_t        v;
    int          cyc, nreq, n, bad;
    logic        moved, seen_req;
    logic [31:0] f_addr, f_wd;
    logic [3:0]  f_be;
    logic        f_we;

    initial begin
        //               pc     instr          rd value         next   cyc mem addr     be       wdata          rdata          wait
        vecs[0]  = mk(32'h00, 32'h00500093, 1, 32'h5,         32'h04, 4, 0, 0,       4'b0000, 0,             0,             0); // ADDI x1,x0,5
        vecs[1]  = mk(32'h04, 32'h00108133, 2, 32'hA,         32'h08, 4, 0, 0,       4'b0000, 0,             0,             0); // ADD x2,x1,x1
        vecs[2]  = mk(32'h08, 32'h0AB00113, 2, 32'hAB,        32'h0C, 4, 0, 0,       4'b0000, 0,             0,             0); // ADDI x2,x0,0xAB
        vecs[3]  = mk(32'h0C, 32'h000011B7, 3, 32'h1000,      32'h10, 4, 0, 0,       4'b0000, 0,             0,             0); // LUI x3,1
        vecs[4]  = mk(32'h10, 32'h002181A3, 0, 0,             32'h14, 7, 2, 32'h1003, 4'b1000, 32'hABABABAB, 0,             3); // SB x2,3(x3)
        vecs[5]  = mk(32'h14, 32'h00218203, 4, 32'hFFFFFF80,  32'h18, 5, 1, 32'h1002, 4'b0100, 0,             32'h00800000,  0); // LB x4,2(x3)
        vecs[6]  = mk(32'h18, 32'h0021C283, 5, 32'h80,        32'h1C, 6, 1, 32'h1002, 4'b0100, 0,             32'h00800000,  1); // LBU x5,2(x3)
        vecs[7]  = mk(32'h1C, 32'h00100313, 6, 32'h1,         32'h20, 4, 0, 0,       4'b0000, 0,             0,             0); // ADDI x6,x0,1
        vecs[8]  = mk(32'h20, 32'hFE000CE3, 0, 0,             32'h18, 3, 0, 0,       4'b0000, 0,             0,             0); // BEQ x0,x0,-8
        vecs[9]  = mk(32'h18, 32'h0080006F, 0, 0,             32'h20, 4, 0, 0,       4'b0000, 0,             0,             0); // JAL x0,+8
        vecs[10] = mk(32'h20, 32'hFE030CE3, 0, 0,             32'h24, 3, 0, 0,       4'b0000, 0,             0,             0); // BEQ x6,x0,-8
        vecs[11] = mk(32'h24, 32'h01C0006F, 0, 0,             32'h40, 4, 0, 0,       4'b0000, 0,             0,             0); // JAL x0,+28
        vecs[12] = mk(32'h40, 32'h010000EF, 1, 32'h44,        32'h50, 4, 0, 0,       4'b0000, 0,             0,             0); // JAL x1,+16
        vecs[13] = mk(32'h50, 32'h00002397, 7, 32'h2050,      32'h54, 4, 0, 0,       4'b0000, 0,             0,             0); // AUIPC x7,2
        vecs[14] = mk(32'h54, 32'h40100433, 8, 32'hFFFFFFBC,  32'h58, 4, 0, 0,       4'b0000, 0,             0,             0); // SUB x8,x0,x1
        vecs[15] = mk(32'h58, 32'h40245493, 9, 32'hFFFFFFEF,  32'h5C, 4, 0, 0,       4'b0000, 0,             0,             0); // SRAI x9,x8,2
        vecs[16] = mk(32'h5C, 32'h0080B533, 10, 32'h1,        32'h60, 4, 0, 0,       4'b0000, 0,             0,             0); // SLTU x10,x1,x8
        vecs[17] = mk(32'h60, 32'h0080A5B3, 11, 32'h0,        32'h64, 4, 0, 0,       4'b0000, 0,             0,             0); // SLT x11,x1,x8
        vecs[18] = mk(32'h64, 32'h0081A023, 0, 0,             32'h68, 4, 2, 32'h1000, 4'b1111, 32'hFFFFFFBC, 0,             0); // SW x8,0(x3)
        vecs[19] = mk(32'h68, 32'h00219603, 12, 32'hFFFF8001, 32'h6C, 5, 1, 32'h1002, 4'b1100, 0,             32'h80010000,  0); // LH x12,2(x3)
        vecs[20] = mk(32'h6C, 32'h00819123, 0, 0,             32'h70, 6, 2, 32'h1002, 4'b1100, 32'hFFBCFFBC, 0,             2); // SH x8,2(x3)
        vecs[21] = mk(32'h70, 32'h03C086E7, 13, 32'h74,       32'h80, 4, 0, 0,       4'b0000, 0,             0,             0); // JALR x13,x1,60

        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        rst_m = 1'b1; rst_e = 1'b1; ready_m = 1'b1; rdata_m = 32'h0;
        repeat (2) @(negedge clk);

        check("rst_pc_main", pc_m, 32'h0);
        check("rst_req_main", {31'b0, req_m}, 32'h0);
        check("rst_be_main", {28'b0, be_m}, 32'h0);
        check("rst_ill_main", {31'b0, ill_m}, 32'h0);
        check("rst_pc_e", pc_e, 32'h100);
        check("rst_req_e", {31'b0, req_e}, 32'h0);
        check("rst_bus_e", {we_e, be_e, 27'b0} | addr_e | wdata_e, 32'h0);

        rst_m = 1'b0; rst_e = 1'b0;
        #1;
        check("first_fetch_e", pc_e, 32'h100);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            imem[v.pc[7:2]] = v.instr;
            rdata_m = v.rdata;
            check($sformatf("v%0d_start_pc", i), pc_m, v.pc);
            cyc = 0; nreq = 0; moved = 1'b0;
            f_addr = '0; f_be = '0; f_we = 1'b0; f_wd = '0;
            while (pc_m == v.pc && cyc < 40) begin
                @(posedge clk); #1; cyc++;
                if (req_m) begin
                    if (nreq == 0) begin
                        f_addr = addr_m; f_be = be_m; f_we = we_m; f_wd = wdata_m;
                    end else if (addr_m !== f_addr || be_m !== f_be || we_m !== f_we || wdata_m !== f_wd) begin
                        moved = 1'b1;
                    end
                    ready_m = (nreq == v.wait_n);
                    nreq++;
                end else begin
                    ready_m = 1'b1;
                end
            end
            ready_m = 1'b1;
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(v.cycles));
            check($sformatf("v%0d_next_pc", i), pc_m, v.next_pc);
            if (v.rd != 0) check($sformatf("v%0d_x%0d", i, v.rd), dut.rf[v.rd], v.val);
            check($sformatf("v%0d_req_cycles", i), 32'(nreq), (v.mem != 0) ? 32'(v.wait_n + 1) : 32'h0);
            if (v.mem != 0) begin
                check($sformatf("v%0d_addr", i), f_addr, v.addr);
                check($sformatf("v%0d_be", i), {28'b0, f_be}, {28'b0, v.be});
                check($sformatf("v%0d_we", i), {31'b0, f_we}, (v.mem == 2) ? 32'h1 : 32'h0);
                check($sformatf("v%0d_bus_stable", i), {31'b0, moved}, 32'h0);
                if (v.mem == 2) check($sformatf("v%0d_wdata", i), f_wd, v.wdata);
            end
        end

        // RV32E core must have trapped on x20 during the program walk
        check("e_trap", {31'b0, ill_e}, 32'h1);
        check("e_pc_frozen", pc_e, 32'h100);

        // Misaligned word load: trap from EXECUTE, never touches the bus
        imem[32] = 32'h0021A703; // LW x14,2(x3) at 0x80
        cyc = 0; seen_req = 1'b0;
        while (!ill_m && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (req_m) seen_req = 1'b1;
        end
        check("lw_trap_cycles", 32'(cyc), 32'd3);
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (req_m || pc_m != 32'h80 || !ill_m) bad++;
        end
        check("lw_trap_hold", 32'(bad), 32'h0);
        check("lw_no_req", {31'b0, seen_req}, 32'h0);

        // Reset in the middle of a stalled store
        @(negedge clk); rst_m = 1'b1; imem[0] = 32'h0081A023; ready_m = 1'b0;
        @(negedge clk);
        check("rst_clears_trap", {31'b0, ill_m}, 32'h0);
        rst_m = 1'b0;
        n = 0;
        while (!req_m && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check("mid_req_latency", 32'(n), 32'd3);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_m = 1'b1; #1;
        check("mid_req_async_drop", {31'b0, req_m}, 32'h0);
        check("mid_pc_reset", pc_m, 32'h0);

        // All-zero opcode is illegal
        imem[0] = 32'h0;
        @(negedge clk); rst_m = 1'b0; ready_m = 1'b1;
        n = 0;
        while (!ill_m && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check("zero_op_trap_cycles", 32'(n), 32'd2);
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (req_m || pc_m != 32'h0 || !ill_m) bad++;
        end
        check("zero_op_trap_hold", 32'(bad), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
